// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: turns the uart_rx byte stream into checksummed, addressed byte writes.
// Frame: SYNC, ADDR, LEN, LEN payload bytes, CSUM (XOR of ADDR, LEN and payload).
// Payload is buffered and only drained to the write port once the checksum verifies.
module uart_rx_packet_ctrl #(
   parameter int unsigned MAX_LEN        = 16,
   parameter int unsigned TIMEOUT_CYCLES = 37500,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic [1:0] err_code,
   output logic [7:0] err_count
);

   localparam int unsigned IW = $clog2(MAX_LEN + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ErrTimeout = 2'd0;
   localparam logic [1:0] ErrLen     = 2'd1;
   localparam logic [1:0] ErrCsum    = 2'd2;
   localparam logic [1:0] ErrOverrun = 2'd3;

   typedef enum logic [2:0] {StIdle, StAddr, StLen, StPayload, StCsum, StDrain} state_t;

   state_t        state_q;
   logic [7:0]    base_q;
   logic [7:0]    len_q;
   logic [7:0]    xor_q;
   logic [IW-1:0] idx_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    pbuf [2**AW];

   logic          tmo_run;
   logic          tmo_hit;
   logic          len_bad;
   logic          last_beat;
   logic [IW-1:0] idx_nxt;
   logic          err_set;
   logic [1:0]    err_set_code;

   assign idx_nxt   = idx_q + 1'b1;
   assign tmo_run   = state_q inside {StAddr, StLen, StPayload, StCsum};
   // A byte in the limit cycle wins over the timeout.
   assign tmo_hit   = tmo_run && !rx_ready && (tmo_q == TW'(TIMEOUT_CYCLES));
   assign len_bad   = (rx_data == 8'd0) || (32'(rx_data) > MAX_LEN);
   assign last_beat = (8'(idx_q) == (len_q - 8'd1));

   // Decode which error, if any, is raised by this cycle's byte or the timeout.
   always_comb begin
      err_set      = 1'b0;
      err_set_code = ErrTimeout;
      case (state_q)
         StLen: begin
            if (rx_ready && len_bad) begin
               err_set      = 1'b1;
               err_set_code = ErrLen;
            end
         end
         StCsum: begin
            if (rx_ready && (rx_data != xor_q)) begin
               err_set      = 1'b1;
               err_set_code = ErrCsum;
            end
         end
         StDrain: begin
            if (rx_ready) begin
               err_set      = 1'b1;
               err_set_code = ErrOverrun;
            end
         end
         default: ;
      endcase
      if (tmo_hit) begin
         err_set      = 1'b1;
         err_set_code = ErrTimeout;
      end
   end

   // Payload storage; left unreset since it is only read after a full packet has landed.
   always_ff @(posedge clk) begin
      if ((state_q == StPayload) && rx_ready) begin
         pbuf[idx_q[AW-1:0]] <= rx_data;
      end
   end

   // Packet sequencer: state, datapath registers and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         base_q    <= '0;
         len_q     <= '0;
         xor_q     <= '0;
         idx_q     <= '0;
         tmo_q     <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         pkt_done  <= 1'b0;
         pkt_err   <= 1'b0;
         err_code  <= '0;
         err_count <= '0;
      end else begin
         pkt_done <= 1'b0;
         pkt_err  <= err_set;
         if (err_set) begin
            err_code <= err_set_code;
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
         end
         tmo_q <= (tmo_run && !rx_ready && !tmo_hit) ? tmo_q + 1'b1 : '0;

         case (state_q)
            StIdle: begin
               if (rx_ready && (rx_data == SYNC_BYTE)) begin
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (rx_ready) begin
                  base_q  <= rx_data;
                  xor_q   <= rx_data;
                  state_q <= StLen;
               end
            end
            StLen: begin
               if (rx_ready) begin
                  if (len_bad) begin
                     state_q <= StIdle;
                  end else begin
                     len_q   <= rx_data;
                     xor_q   <= xor_q ^ rx_data;
                     idx_q   <= '0;
                     state_q <= StPayload;
                  end
               end
            end
            StPayload: begin
               if (rx_ready) begin
                  xor_q <= xor_q ^ rx_data;
                  idx_q <= idx_nxt;
                  if (8'(idx_nxt) == len_q) begin
                     state_q <= StCsum;
                  end
               end
            end
            StCsum: begin
               if (rx_ready) begin
                  if (rx_data == xor_q) begin
                     state_q  <= StDrain;
                     idx_q    <= '0;
                     wr_valid <= 1'b1;
                     wr_addr  <= base_q;
                     wr_data  <= pbuf[0];
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StDrain: begin
               // Incoming bytes here are dropped; only the overrun error reacts to them.
               if (wr_valid && wr_ready) begin
                  if (last_beat) begin
                     wr_valid <= 1'b0;
                     pkt_done <= 1'b1;
                     idx_q    <= '0;
                     state_q  <= StIdle;
                  end else begin
                     idx_q   <= idx_nxt;
                     wr_addr <= wr_addr + 8'd1;
                     wr_data <= pbuf[idx_nxt[AW-1:0]];
                  end
               end
            end
            default: state_q <= StIdle;
         endcase

         if (tmo_hit) begin
            state_q <= StIdle;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl; small timeout so limit cases run quickly.
module tb_uart_rx_packet_ctrl;

   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       pkt_done;
   logic       pkt_err;
   logic [1:0] err_code;
   logic [7:0] err_count;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] beat_a[$];
   logic [7:0] beat_d[$];
   int done_seen = 0;
   int err_seen  = 0;
   logic [7:0] pk[$];

   always #5 clk = ~clk;

   uart_rx_packet_ctrl #(
      .MAX_LEN       (16),
      .TIMEOUT_CYCLES(TO),
      .SYNC_BYTE     (8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .pkt_done (pkt_done),
      .pkt_err  (pkt_err),
      .err_code (err_code),
      .err_count(err_count)
   );

   // Record transferred beats and pulses as the DUT presents them at each edge.
   always @(posedge clk) begin
      if (wr_valid && wr_ready) begin
         beat_a.push_back(wr_addr);
         beat_d.push_back(wr_data);
      end
      if (pkt_done) done_seen <= done_seen + 1;
      if (pkt_err)  err_seen  <= err_seen + 1;
   end

   // Strobe one byte for one cycle; called and returns on a negedge.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send(s[i]);
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_seen > d0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; wr_ready = 1'b0;
      #3;
      n_chk++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
      n_chk++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
      n_chk++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
      n_chk++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
      n_chk++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_err: got %b want 0", pkt_err); end
      n_chk++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
      n_chk++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_good_packet;
      int d0 = done_seen;
      int e0 = err_seen;
      wr_ready = 1'b1;
      pk = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
      send_seq(pk);
      n_chk++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h10, 8'h11}) begin n_fail++;
         $display("FAIL good_beat0: got v=%b a=%h d=%h want v=1 a=10 d=11", wr_valid, wr_addr, wr_data); end
      @(negedge clk);
      n_chk++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h11, 8'h22}) begin n_fail++;
         $display("FAIL good_beat1: got v=%b a=%h d=%h want v=1 a=11 d=22", wr_valid, wr_addr, wr_data); end
      @(negedge clk);
      n_chk++; if ({wr_valid, pkt_done} !== 2'b01) begin n_fail++;
         $display("FAIL good_done: got v=%b done=%b want v=0 done=1", wr_valid, pkt_done); end
      @(negedge clk);
      n_chk++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL good_done_width: got %b want 0", pkt_done); end
      n_chk++; if (done_seen - d0 != 1) begin n_fail++; $display("FAIL good_done_count: got %0d want 1", done_seen - d0); end
      n_chk++; if (err_seen != e0) begin n_fail++; $display("FAIL good_no_err: got %0d pulses want 0", err_seen - e0); end
   endtask

   task automatic test_bad_csum;
      int b0 = beat_a.size();
      int d0;
      bit ok;
      pk = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
      send_seq(pk);
      n_chk++; if ({pkt_err, err_code} !== {1'b1, 2'd2}) begin n_fail++;
         $display("FAIL csum_err: got err=%b code=%0d want err=1 code=2", pkt_err, err_code); end
      n_chk++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL csum_count: got %0d want 1", err_count); end
      repeat (4) @(negedge clk);
      n_chk++; if (beat_a.size() != b0 || wr_valid !== 1'b0) begin n_fail++;
         $display("FAIL csum_no_write: got %0d beats v=%b want 0 beats v=0", beat_a.size() - b0, wr_valid); end
      n_chk++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL csum_err_width: got %b want 0", pkt_err); end
      d0 = done_seen;
      pk = '{8'hA5, 8'h30, 8'h01, 8'h77, 8'h46};
      send_seq(pk);
      wait_done(d0, 10, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL csum_recover_done: got no pkt_done want 1"); end
      n_chk++; if (beat_a.size() != b0 + 1 || beat_a[b0] !== 8'h30 || beat_d[b0] !== 8'h77) begin n_fail++;
         $display("FAIL csum_recover_beat: got %0d beats want 1 beat a=30 d=77", beat_a.size() - b0); end
   endtask

   task automatic test_len;
      logic [7:0] p[16];
      logic [7:0] cs;
      logic [7:0] ea;
      int b0;
      int d0;
      bit ok;
      pk = '{8'hA5, 8'h10, 8'h00};
      send_seq(pk);
      n_chk++; if ({pkt_err, err_code, err_count} !== {1'b1, 2'd1, 8'd2}) begin n_fail++;
         $display("FAIL len0: got err=%b code=%0d cnt=%0d want 1/1/2", pkt_err, err_code, err_count); end
      @(negedge clk);
      pk = '{8'hA5, 8'h10, 8'h11};
      send_seq(pk);
      n_chk++; if ({pkt_err, err_code, err_count} !== {1'b1, 2'd1, 8'd3}) begin n_fail++;
         $display("FAIL len17: got err=%b code=%0d cnt=%0d want 1/1/3", pkt_err, err_code, err_count); end
      @(negedge clk);
      cs = 8'hFE ^ 8'h10;
      pk = '{8'hA5, 8'hFE, 8'h10};
      for (int i = 0; i < 16; i++) begin
         p[i] = 8'(i * 7 + 3);
         cs   = cs ^ p[i];
         pk.push_back(p[i]);
      end
      pk.push_back(cs);
      b0 = beat_a.size();
      d0 = done_seen;
      send_seq(pk);
      wait_done(d0, 40, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL len16_done: got no pkt_done want 1"); end
      n_chk++; if (beat_a.size() != b0 + 16) begin n_fail++;
         $display("FAIL len16_beats: got %0d want 16", beat_a.size() - b0); end
      else begin
         for (int i = 0; i < 16; i++) begin
            ea = 8'hFE + 8'(i);
            n_chk++; if (beat_a[b0+i] !== ea || beat_d[b0+i] !== p[i]) begin n_fail++;
               $display("FAIL len16_beat%0d: got a=%h d=%h want a=%h d=%h", i, beat_a[b0+i], beat_d[b0+i], ea, p[i]); end
         end
      end
      n_chk++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL len16_count: got %0d want 3", err_count); end
   endtask

   task automatic test_timeout;
      int e0 = err_seen;
      int b0 = beat_a.size();
      int d0;
      bit ok;
      pk = '{8'hA5, 8'h10, 8'h02, 8'h11};
      send_seq(pk);
      repeat (TO) @(negedge clk);
      n_chk++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", pkt_err); end
      @(negedge clk);
      n_chk++; if ({pkt_err, err_code, err_count} !== {1'b1, 2'd0, 8'd4}) begin n_fail++;
         $display("FAIL tmo_pulse: got err=%b code=%0d cnt=%0d want 1/0/4", pkt_err, err_code, err_count); end
      pk = '{8'h22, 8'h21};
      send_seq(pk);
      repeat (TO + 5) @(negedge clk);
      n_chk++; if (err_seen != e0 + 1 || beat_a.size() != b0) begin n_fail++;
         $display("FAIL tmo_idle: got %0d errs %0d beats want 1 err 0 beats", err_seen - e0, beat_a.size() - b0); end
      d0 = done_seen;
      pk = '{8'hA5, 8'h10, 8'h01};
      send_seq(pk);
      repeat (TO) @(negedge clk);
      send(8'h55);
      n_chk++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL tmo_limit_payload: got %b want 0", pkt_err); end
      repeat (TO) @(negedge clk);
      send(8'h44);
      n_chk++; if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL tmo_limit_csum: got %b want 0", pkt_err); end
      wait_done(d0, 10, ok);
      n_chk++; if (!ok || beat_a.size() != b0 + 1 || beat_a[b0] !== 8'h10 || beat_d[b0] !== 8'h55) begin n_fail++;
         $display("FAIL tmo_limit_pkt: got done=%b beats=%0d want done=1 one beat a=10 d=55", ok, beat_a.size() - b0); end
      n_chk++; if (err_count !== 8'd4) begin n_fail++; $display("FAIL tmo_limit_count: got %0d want 4", err_count); end
   endtask

   task automatic test_stall_overrun;
      int b0 = beat_a.size();
      int d0 = done_seen;
      int e0 = err_seen;
      bit ok = 1'b0;
      wr_ready = 1'b0;
      pk = '{8'hA5, 8'h40, 8'h03, 8'h01, 8'h02, 8'h03, 8'h43};
      send_seq(pk);
      n_chk++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h40, 8'h01}) begin n_fail++;
         $display("FAIL stall_first: got v=%b a=%h d=%h want 1/40/01", wr_valid, wr_addr, wr_data); end
      @(negedge clk);
      send(8'hA5);
      n_chk++; if ({pkt_err, err_code, err_count} !== {1'b1, 2'd3, 8'd5}) begin n_fail++;
         $display("FAIL overrun: got err=%b code=%0d cnt=%0d want 1/3/5", pkt_err, err_code, err_count); end
      n_chk++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h40, 8'h01}) begin n_fail++;
         $display("FAIL stall_hold: got v=%b a=%h d=%h want 1/40/01", wr_valid, wr_addr, wr_data); end
      for (int i = 0; i < 40; i++) begin
         if (done_seen > d0) begin
            ok = 1'b1;
            break;
         end
         wr_ready = ~wr_ready;
         @(negedge clk);
      end
      n_chk++; if (!ok) begin n_fail++; $display("FAIL stall_done: got no pkt_done want 1"); end
      n_chk++; if (beat_a.size() != b0 + 3 || beat_a[b0] !== 8'h40 || beat_d[b0] !== 8'h01 ||
                   beat_a[b0+1] !== 8'h41 || beat_d[b0+1] !== 8'h02 ||
                   beat_a[b0+2] !== 8'h42 || beat_d[b0+2] !== 8'h03) begin n_fail++;
         $display("FAIL stall_beats: got %0d beats want 40/01 41/02 42/03", beat_a.size() - b0); end
      n_chk++; if (err_seen != e0 + 1 || done_seen != d0 + 1) begin n_fail++;
         $display("FAIL stall_pulses: got errs=%0d dones=%0d want 1/1", err_seen - e0, done_seen - d0); end
      wr_ready = 1'b1;
   endtask

   task automatic test_garbage_reset;
      int e0 = err_seen;
      int b0;
      int d0;
      bit ok;
      pk = '{8'h00, 8'hFF, 8'h5A};
      send_seq(pk);
      repeat (3) @(negedge clk);
      n_chk++; if (err_seen != e0 || err_count !== 8'd5) begin n_fail++;
         $display("FAIL garbage: got errs=%0d cnt=%0d want 0/5", err_seen - e0, err_count); end
      pk = '{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02};
      send_seq(pk);
      #2 rst = 1'b0;
      #1;
      n_chk++; if ({wr_valid, wr_addr, wr_data, pkt_done, pkt_err, err_code, err_count} !== 29'd0) begin n_fail++;
         $display("FAIL midreset: got v=%b a=%h d=%h done=%b err=%b code=%0d cnt=%0d want all 0",
                  wr_valid, wr_addr, wr_data, pkt_done, pkt_err, err_code, err_count); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      b0 = beat_a.size();
      d0 = done_seen;
      e0 = err_seen;
      pk = '{8'hA5, 8'h20, 8'h02, 8'h0A, 8'h0B, 8'h23};
      send_seq(pk);
      wait_done(d0, 10, ok);
      n_chk++; if (!ok || beat_a.size() != b0 + 2 || beat_a[b0] !== 8'h20 || beat_d[b0] !== 8'h0A ||
                   beat_a[b0+1] !== 8'h21 || beat_d[b0+1] !== 8'h0B) begin n_fail++;
         $display("FAIL post_reset_pkt: got done=%b beats=%0d want done=1 20/0A 21/0B", ok, beat_a.size() - b0); end
      repeat (TO + 5) @(negedge clk);
      n_chk++; if (err_seen != e0 || err_count !== 8'd0) begin n_fail++;
         $display("FAIL post_reset_err: got errs=%0d cnt=%0d want 0/0", err_seen - e0, err_count); end
   endtask

   initial begin
      test_reset();
      test_good_packet();
      test_bad_csum();
      test_len();
      test_timeout();
      test_stall_overrun();
      test_garbage_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
